// File: rtl/alu_issue_queue.sv
// Age-ordered collapsing issue queue in front of the ALU.
// Holds decoded ALU ops whose source operands may still be pending, captures
// operand values from the writeback broadcast, and issues the oldest ready op
// to the ALU (one per cycle; the ALU always accepts).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (priority over flush)
//   flush_i           discard all entries; same-cycle enqueue/wakeup dropped
//   enq_*             dispatch interface (valid/ready handshake, op fields,
//                     per-operand ready flag, producer tag and value)
//   wb_*              writeback broadcast (valid, producer sid, value)
//   alu_*             issued op, driven from registered state only
//   count_o           number of valid entries
module alu_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SID_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [SID_W-1:0]           enq_sid_i,
    input  logic [2:0]                 enq_func3_i,
    input  logic                       enq_auipc_i,
    input  logic [63:0]                enq_pc_i,
    input  logic [31:0]                enq_inst_i,
    input  logic [3:0]                 enq_func_code_i,
    input  logic                       enq_rs1_rdy_i,
    input  logic [SID_W-1:0]           enq_rs1_tag_i,
    input  logic [63:0]                enq_rs1_val_i,
    input  logic                       enq_rs2_rdy_i,
    input  logic [SID_W-1:0]           enq_rs2_tag_i,
    input  logic [63:0]                enq_rs2_val_i,
    input  logic                       wb_valid_i,
    input  logic [SID_W-1:0]           wb_sid_i,
    input  logic [63:0]                wb_value_i,
    output logic                       alu_valid_o,
    output logic [SID_W-1:0]           alu_sid_o,
    output logic [2:0]                 alu_func3_o,
    output logic                       alu_auipc_o,
    output logic [63:0]                alu_pc_o,
    output logic [31:0]                alu_inst_o,
    output logic [63:0]                alu_rs1_value_o,
    output logic [63:0]                alu_rs2_value_o,
    output logic [3:0]                 alu_func_code_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [SID_W-1:0] sid;
        logic [2:0]       func3;
        logic             auipc;
        logic [63:0]      pc;
        logic [31:0]      inst;
        logic [3:0]       func_code;
        logic             rs1_rdy;
        logic [SID_W-1:0] rs1_tag;
        logic [63:0]      rs1_val;
        logic             rs2_rdy;
        logic [SID_W-1:0] rs2_tag;
        logic [63:0]      rs2_val;
    } entry_t;

    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [DEPTH-1:0] valid;
    logic            issue;
    logic [CW-1:0]   issue_idx;
    entry_t          iss;
    entry_t          enq_ent;
    logic            enq_fire;
    logic [CW-1:0]   enq_pos;

    // Capture a matching writeback into any operand still waiting.
    function automatic entry_t wake(entry_t e, logic v, logic [SID_W-1:0] sid,
                                    logic [63:0] val);
        entry_t r;
        r = e;
        if (v && !e.rs1_rdy && (e.rs1_tag == sid)) begin
            r.rs1_rdy = 1'b1;
            r.rs1_val = val;
        end
        if (v && !e.rs2_rdy && (e.rs2_tag == sid)) begin
            r.rs2_rdy = 1'b1;
            r.rs2_val = val;
        end
        return r;
    endfunction

    // Oldest-ready select; scanning downward leaves the lowest index last.
    always_comb begin
        issue     = 1'b0;
        issue_idx = '0;
        iss       = ent_q[0];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            valid[i] = (CW'(i) < count_q);
            if (valid[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                issue     = 1'b1;
                issue_idx = CW'(i);
                iss       = ent_q[i];
            end
        end
    end

    assign enq_ready_o = (count_q < CW'(DEPTH));
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign enq_pos     = count_q - CW'(issue);

    always_comb begin
        enq_ent.sid       = enq_sid_i;
        enq_ent.func3     = enq_func3_i;
        enq_ent.auipc     = enq_auipc_i;
        enq_ent.pc        = enq_pc_i;
        enq_ent.inst      = enq_inst_i;
        enq_ent.func_code = enq_func_code_i;
        enq_ent.rs1_rdy   = enq_rs1_rdy_i;
        enq_ent.rs1_tag   = enq_rs1_tag_i;
        enq_ent.rs1_val   = enq_rs1_val_i;
        enq_ent.rs2_rdy   = enq_rs2_rdy_i;
        enq_ent.rs2_tag   = enq_rs2_tag_i;
        enq_ent.rs2_val   = enq_rs2_val_i;
    end

    // Collapse above the issued slot, apply wakeups to entries as they move,
    // then drop the new op (with bypass wakeup) at the first free slot.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_d[j] = wake(ent_q[j], wb_valid_i, wb_sid_i, wb_value_i);
            if (issue && (CW'(j) >= issue_idx) && (j < DEPTH - 1)) begin
                ent_d[j] = wake(ent_q[j+1], wb_valid_i, wb_sid_i, wb_value_i);
            end
            if (enq_fire && (CW'(j) == enq_pos)) begin
                ent_d[j] = wake(enq_ent, wb_valid_i, wb_sid_i, wb_value_i);
            end
        end
        count_d = count_q + CW'(enq_fire) - CW'(issue);
    end

    // Entry payloads need no reset: validity is derived from count_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
        for (int k = 0; k < DEPTH; k++) begin
            ent_q[k] <= ent_d[k];
        end
    end

    assign count_o         = count_q;
    assign alu_valid_o     = issue;
    assign alu_sid_o       = iss.sid;
    assign alu_func3_o     = iss.func3;
    assign alu_auipc_o     = iss.auipc;
    assign alu_pc_o        = iss.pc;
    assign alu_inst_o      = iss.inst;
    assign alu_rs1_value_o = iss.rs1_val;
    assign alu_rs2_value_o = iss.rs2_val;
    assign alu_func_code_o = iss.func_code;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue (DEPTH=4, SID_W=3).
module tb_alu_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SID_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic             enq_valid_i;
    logic             enq_ready_o;
    logic [SID_W-1:0] enq_sid_i;
    logic [2:0]       enq_func3_i;
    logic             enq_auipc_i;
    logic [63:0]      enq_pc_i;
    logic [31:0]      enq_inst_i;
    logic [3:0]       enq_func_code_i;
    logic             enq_rs1_rdy_i;
    logic [SID_W-1:0] enq_rs1_tag_i;
    logic [63:0]      enq_rs1_val_i;
    logic             enq_rs2_rdy_i;
    logic [SID_W-1:0] enq_rs2_tag_i;
    logic [63:0]      enq_rs2_val_i;
    logic             wb_valid_i;
    logic [SID_W-1:0] wb_sid_i;
    logic [63:0]      wb_value_i;
    logic             alu_valid_o;
    logic [SID_W-1:0] alu_sid_o;
    logic [2:0]       alu_func3_o;
    logic             alu_auipc_o;
    logic [63:0]      alu_pc_o;
    logic [31:0]      alu_inst_o;
    logic [63:0]      alu_rs1_value_o;
    logic [63:0]      alu_rs2_value_o;
    logic [3:0]       alu_func_code_o;
    logic [2:0]       count_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_issue_queue #(.DEPTH(DEPTH), .SID_W(SID_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_sid_i(enq_sid_i), .enq_func3_i(enq_func3_i), .enq_auipc_i(enq_auipc_i),
        .enq_pc_i(enq_pc_i), .enq_inst_i(enq_inst_i), .enq_func_code_i(enq_func_code_i),
        .enq_rs1_rdy_i(enq_rs1_rdy_i), .enq_rs1_tag_i(enq_rs1_tag_i),
        .enq_rs1_val_i(enq_rs1_val_i), .enq_rs2_rdy_i(enq_rs2_rdy_i),
        .enq_rs2_tag_i(enq_rs2_tag_i), .enq_rs2_val_i(enq_rs2_val_i),
        .wb_valid_i(wb_valid_i), .wb_sid_i(wb_sid_i), .wb_value_i(wb_value_i),
        .alu_valid_o(alu_valid_o), .alu_sid_o(alu_sid_o), .alu_func3_o(alu_func3_o),
        .alu_auipc_o(alu_auipc_o), .alu_pc_o(alu_pc_o), .alu_inst_o(alu_inst_o),
        .alu_rs1_value_o(alu_rs1_value_o), .alu_rs2_value_o(alu_rs2_value_o),
        .alu_func_code_o(alu_func_code_o), .count_o(count_o)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst         = 1'b0;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        wb_valid_i  = 1'b0;
        wb_sid_i    = '0;
        wb_value_i  = '0;
    endtask

    task automatic drive_enq(input logic [2:0] sid, input logic r1, input logic [2:0] t1,
                             input logic [63:0] v1, input logic r2, input logic [2:0] t2,
                             input logic [63:0] v2);
        enq_valid_i     = 1'b1;
        enq_sid_i       = sid;
        enq_func3_i     = sid;
        enq_auipc_i     = sid[0];
        enq_pc_i        = 64'h1000 + 64'(sid);
        enq_inst_i      = 32'h13 + 32'(sid);
        enq_func_code_i = {1'b0, sid};
        enq_rs1_rdy_i   = r1;
        enq_rs1_tag_i   = t1;
        enq_rs1_val_i   = v1;
        enq_rs2_rdy_i   = r2;
        enq_rs2_tag_i   = t2;
        enq_rs2_val_i   = v2;
    endtask

    task automatic drive_wb(input logic [2:0] sid, input logic [63:0] val);
        wb_valid_i = 1'b1;
        wb_sid_i   = sid;
        wb_value_i = val;
    endtask

    task automatic test_reset();
        idle_inputs();
        drive_enq(3'd0, 1'b1, 3'd0, 64'd0, 1'b1, 3'd0, 64'd0);
        rst = 1'b1;
        tick();
        tick();
        idle_inputs();
        tests++;
        if (count_o !== 3'd0) begin
            fails++; $display("FAIL reset_count got %0d want 0", count_o);
        end
        tests++;
        if (alu_valid_o !== 1'b0) begin
            fails++; $display("FAIL reset_valid got %b want 0", alu_valid_o);
        end
        tests++;
        if (enq_ready_o !== 1'b1) begin
            fails++; $display("FAIL reset_ready got %b want 1", enq_ready_o);
        end
    endtask

    task automatic test_basic();
        drive_enq(3'd1, 1'b1, 3'd0, 64'd5, 1'b1, 3'd0, 64'd7);
        tick();
        idle_inputs();
        tests++;
        if ({alu_valid_o, alu_sid_o} !== {1'b1, 3'd1}) begin
            fails++; $display("FAIL basic_issue got v=%b sid=%0d want v=1 sid=1",
                              alu_valid_o, alu_sid_o);
        end
        tests++;
        if ({alu_rs1_value_o, alu_rs2_value_o} !== {64'd5, 64'd7}) begin
            fails++; $display("FAIL basic_vals got %0d/%0d want 5/7",
                              alu_rs1_value_o, alu_rs2_value_o);
        end
        tests++;
        if ({alu_pc_o, alu_inst_o, alu_func3_o, alu_auipc_o, alu_func_code_o} !==
            {64'h1001, 32'h14, 3'd1, 1'b1, 4'd1}) begin
            fails++; $display("FAIL basic_fields got pc=%h inst=%h f3=%0d au=%b fc=%0d",
                              alu_pc_o, alu_inst_o, alu_func3_o, alu_auipc_o,
                              alu_func_code_o);
        end
        tick();
        tests++;
        if ({alu_valid_o, count_o} !== {1'b0, 3'd0}) begin
            fails++; $display("FAIL basic_drain got v=%b cnt=%0d want v=0 cnt=0",
                              alu_valid_o, count_o);
        end
    endtask

    task automatic test_order();
        drive_enq(3'd2, 1'b0, 3'd6, 64'd0, 1'b1, 3'd0, 64'd9);
        tick();
        drive_enq(3'd3, 1'b1, 3'd0, 64'd11, 1'b1, 3'd0, 64'd12);
        tick();
        idle_inputs();
        tests++;
        if ({alu_valid_o, alu_sid_o, count_o} !== {1'b1, 3'd3, 3'd2}) begin
            fails++; $display("FAIL order_young_first got v=%b sid=%0d cnt=%0d want 1/3/2",
                              alu_valid_o, alu_sid_o, count_o);
        end
        tick();
        drive_wb(3'd6, 64'h1234);
        #1;
        tests++;
        if (alu_valid_o !== 1'b0) begin
            fails++; $display("FAIL order_no_same_cycle_wake got %b want 0", alu_valid_o);
        end
        tick();
        idle_inputs();
        tests++;
        if ({alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o} !==
            {1'b1, 3'd2, 64'h1234, 64'd9}) begin
            fails++; $display("FAIL order_woken got v=%b sid=%0d rs1=%h rs2=%0d want 1/2/1234/9",
                              alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o);
        end
        tick();
        tests++;
        if (count_o !== 3'd0) begin
            fails++; $display("FAIL order_drain got %0d want 0", count_o);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive_enq(3'(i), 1'b0, 3'(i + 4), 64'd0, 1'b1, 3'd0, 64'(i * 16));
            tick();
        end
        tests++;
        if ({count_o, enq_ready_o, alu_valid_o} !== {3'd4, 1'b0, 1'b0}) begin
            fails++; $display("FAIL full_state got cnt=%0d rdy=%b v=%b want 4/0/0",
                              count_o, enq_ready_o, alu_valid_o);
        end
        drive_enq(3'd5, 1'b1, 3'd0, 64'd1, 1'b1, 3'd0, 64'd2);
        tick();
        idle_inputs();
        tests++;
        if ({count_o, alu_valid_o} !== {3'd4, 1'b0}) begin
            fails++; $display("FAIL full_enq_ignored got cnt=%0d v=%b want 4/0",
                              count_o, alu_valid_o);
        end
        drive_wb(3'd5, 64'h55);
        tick();
        idle_inputs();
        tests++;
        if ({alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o} !==
            {1'b1, 3'd1, 64'h55, 64'd16}) begin
            fails++; $display("FAIL full_wake_mid got v=%b sid=%0d rs1=%h rs2=%0d want 1/1/55/16",
                              alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o);
        end
        tick();
        tests++;
        if ({count_o, enq_ready_o, alu_valid_o} !== {3'd3, 1'b1, 1'b0}) begin
            fails++; $display("FAIL full_after_issue got cnt=%0d rdy=%b v=%b want 3/1/0",
                              count_o, enq_ready_o, alu_valid_o);
        end
        // sid 3 has shifted from index 3 to 2; wake it there.
        drive_wb(3'd7, 64'h77);
        tick();
        idle_inputs();
        tests++;
        if ({alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o} !==
            {1'b1, 3'd3, 64'h77, 64'd48}) begin
            fails++; $display("FAIL full_shifted got v=%b sid=%0d rs1=%h rs2=%0d want 1/3/77/48",
                              alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o);
        end
        tick();
        tests++;
        if (count_o !== 3'd2) begin
            fails++; $display("FAIL full_count2 got %0d want 2", count_o);
        end
        flush_i = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_bypass();
        drive_enq(3'd1, 1'b0, 3'd4, 64'd0, 1'b1, 3'd0, 64'd3);
        drive_wb(3'd4, 64'hAB);
        tick();
        idle_inputs();
        tests++;
        if ({alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o} !==
            {1'b1, 3'd1, 64'hAB, 64'd3}) begin
            fails++; $display("FAIL bypass got v=%b sid=%0d rs1=%h rs2=%0d want 1/1/ab/3",
                              alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o);
        end
        tick();
        tests++;
        if (count_o !== 3'd0) begin
            fails++; $display("FAIL bypass_drain got %0d want 0", count_o);
        end
    endtask

    task automatic test_enq_issue();
        drive_enq(3'd0, 1'b0, 3'd6, 64'd0, 1'b1, 3'd0, 64'd1);
        tick();
        drive_enq(3'd1, 1'b0, 3'd7, 64'd0, 1'b1, 3'd0, 64'd2);
        tick();
        idle_inputs();
        drive_wb(3'd6, 64'h60);
        tick();
        idle_inputs();
        tests++;
        if ({alu_valid_o, alu_sid_o, count_o} !== {1'b1, 3'd0, 3'd2}) begin
            fails++; $display("FAIL ei_pre got v=%b sid=%0d cnt=%0d want 1/0/2",
                              alu_valid_o, alu_sid_o, count_o);
        end
        // Issue of sid 0 and enqueue of sid 2 share this edge; sid 2 shares tag 7 with sid 1.
        drive_enq(3'd2, 1'b0, 3'd7, 64'd0, 1'b1, 3'd0, 64'd3);
        tick();
        idle_inputs();
        tests++;
        if ({count_o, alu_valid_o} !== {3'd2, 1'b0}) begin
            fails++; $display("FAIL ei_count got cnt=%0d v=%b want 2/0", count_o, alu_valid_o);
        end
        drive_wb(3'd7, 64'h70);
        tick();
        idle_inputs();
        tests++;
        if ({alu_valid_o, alu_sid_o, alu_rs1_value_o} !== {1'b1, 3'd1, 64'h70}) begin
            fails++; $display("FAIL ei_oldest got v=%b sid=%0d rs1=%h want 1/1/70",
                              alu_valid_o, alu_sid_o, alu_rs1_value_o);
        end
        tick();
        tests++;
        if ({alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o} !==
            {1'b1, 3'd2, 64'h70, 64'd3}) begin
            fails++; $display("FAIL ei_second got v=%b sid=%0d rs1=%h rs2=%0d want 1/2/70/3",
                              alu_valid_o, alu_sid_o, alu_rs1_value_o, alu_rs2_value_o);
        end
        tick();
        tests++;
        if (count_o !== 3'd0) begin
            fails++; $display("FAIL ei_drain got %0d want 0", count_o);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive_enq(3'(i), 1'b0, 3'(i + 5), 64'd0, 1'b1, 3'd0, 64'd0);
            tick();
        end
        tests++;
        if (count_o !== 3'd3) begin
            fails++; $display("FAIL flush_pre got %0d want 3", count_o);
        end
        flush_i = 1'b1;
        drive_enq(3'd3, 1'b1, 3'd0, 64'd1, 1'b1, 3'd0, 64'd1);
        drive_wb(3'd5, 64'h5);
        tick();
        idle_inputs();
        tests++;
        if ({count_o, alu_valid_o, enq_ready_o} !== {3'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL flush_state got cnt=%0d v=%b rdy=%b want 0/0/1",
                              count_o, alu_valid_o, enq_ready_o);
        end
        tick();
        tests++;
        if ({count_o, alu_valid_o} !== {3'd0, 1'b0}) begin
            fails++; $display("FAIL flush_dropped got cnt=%0d v=%b want 0/0",
                              count_o, alu_valid_o);
        end
    endtask

    task automatic test_rst_mid();
        drive_enq(3'd1, 1'b0, 3'd5, 64'd0, 1'b1, 3'd0, 64'd0);
        tick();
        drive_enq(3'd2, 1'b1, 3'd0, 64'd4, 1'b1, 3'd0, 64'd4);
        tick();
        tests++;
        if (count_o !== 3'd2) begin
            fails++; $display("FAIL rst_pre got %0d want 2", count_o);
        end
        rst = 1'b1;
        drive_wb(3'd5, 64'h9);
        tick();
        idle_inputs();
        tests++;
        if ({count_o, alu_valid_o, enq_ready_o} !== {3'd0, 1'b0, 1'b1}) begin
            fails++; $display("FAIL rst_mid got cnt=%0d v=%b rdy=%b want 0/0/1",
                              count_o, alu_valid_o, enq_ready_o);
        end
    endtask

    initial begin
        idle_inputs();
        drive_enq(3'd0, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0);
        enq_valid_i = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_order();
        test_full();
        test_bypass();
        test_enq_issue();
        test_flush();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Small age-ordered issue queue in front of the ALU.
- Holds decoded ALU ops whose source operands may still be pending.
- Captures operand values from the writeback broadcast and sends the oldest ready op to the ALU, one per cycle.
- Sits between operand read/dispatch and the ALU; drives the ALU's valid/sid/func3/auipc/pc/inst/rs1/rs2/func_code inputs.

Parameters:
DEPTH, 4, number of queue entries (power of two not required, >=2)
SID_W, 3, scoreboard id width (matches SCOREBOARD_SIZE_WIDTH)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
flush_i  input  1  discard all entries
enq_valid_i  input  1  dispatch offers an op
enq_ready_o  output  1  queue can accept an op this cycle
enq_sid_i  input  SID_W  scoreboard id of the op
enq_func3_i  input  3  func3 field
enq_auipc_i  input  1  op is AUIPC
enq_pc_i  input  64  pc
enq_inst_i  input  32  instruction word
enq_func_code_i  input  4  func code
enq_rs1_rdy_i  input  1  rs1 value valid at dispatch
enq_rs1_tag_i  input  SID_W  producer sid for rs1 when not ready
enq_rs1_val_i  input  64  rs1 value when ready
enq_rs2_rdy_i  input  1  rs2 value valid at dispatch
enq_rs2_tag_i  input  SID_W  producer sid for rs2 when not ready
enq_rs2_val_i  input  64  rs2 value when ready
wb_valid_i  input  1  writeback broadcast valid
wb_sid_i  input  SID_W  sid of the producing op
wb_value_i  input  64  result value
alu_valid_o  output  1  op issued to the ALU this cycle
alu_sid_o  output  SID_W  issued op sid
alu_func3_o  output  3  issued func3
alu_auipc_o  output  1  issued auipc flag
alu_pc_o  output  64  issued pc
alu_inst_o  output  32  issued instruction
alu_rs1_value_o  output  64  issued rs1 value
alu_rs2_value_o  output  64  issued rs2 value
alu_func_code_o  output  4  issued func code
count_o  output  $clog2(DEPTH+1)  valid entries

Behaviour:
- Reset/flush (sync, rst has priority over flush):
  - All entries invalid, count_o=0, alu_valid_o=0, enq_ready_o=1.
  - Any enqueue or wakeup presented in the flush cycle is dropped.
- Storage: collapsing queue; entry 0 is oldest; valid entries are contiguous from index 0.
- Per-entry ready: rsN_rdy flags held in registers.
- Select (combinational from registered state only):
  - Issue slot = lowest index with valid & rs1_rdy & rs2_rdy.
  - alu_valid_o=1 iff such an entry exists; all alu_*_o fields come from that entry.
  - With alu_valid_o=0, the alu_*_o data fields are don't-care.
  - The ALU always accepts, so issue takes effect every cycle alu_valid_o=1.
  - No input-to-alu_*_o combinational path.
- Issue removal: at the clock edge the issued entry is removed and every valid entry above it shifts down one index. Relative age is kept.
- Enqueue:
  - enq_ready_o = (count_o < DEPTH). This is registered-state based and does not count a same-cycle issue.
  - A transfer happens when enq_valid_i & enq_ready_o.
  - The new entry goes to index count_o, or count_o-1 if an issue happens the same cycle.
- Wakeup, for each valid entry and each operand with rdy=0:
  - If wb_valid_i and wb_sid_i == tag, set rdy=1 and value=wb_value_i at the edge.
  - Applies to shifting entries too: the wakeup follows the entry to its new index.
- Enqueue/wakeup bypass: if an enqueued operand is not ready and its tag matches the wb broadcast in the same cycle, it is written ready with wb_value_i.
- Latency:
  - An op enqueued with both operands ready, or woken, can issue the cycle after the enqueue or wakeup edge.
  - A wakeup never enables issue in the same cycle it arrives.
- count_o update: next = count + enq - issue. Enqueue and issue in the same cycle at full is impossible by construction, since enq_ready_o=0 when full.
- Both operands waiting on the same tag: both wake together.
- The broadcast sid of an op still inside the queue is ignored. It has no matching tag by construction; no check is required.

Test Plan:
- Reset, then enqueue sid=1 with rs1=5, rs2=7, both ready -> next cycle alu_valid_o=1, alu_sid_o=1, alu_rs1_value_o=5, alu_rs2_value_o=7; the cycle after, alu_valid_o=0, count_o=0.
- Enqueue sid=2 (rs1 waits on tag 6), then sid=3 (all ready) -> sid=3 issues first. Broadcast wb_sid=6, value=0x1234 -> next cycle sid=2 issues with rs1=0x1234.
- Fill 4 not-ready entries -> enq_ready_o=0 and enq_valid_i is ignored. Wake entry 1 -> it issues, entries 2..3 shift to 1..2, count_o=3, enq_ready_o=1.
- Enqueue in the same cycle as a matching wb (tag 4, value 0xAB) -> entry stored ready; it issues next cycle with value 0xAB.
- Enqueue and issue in the same cycle with count_o=2 -> new entry lands at index 1, count_o stays 2, age order preserved on subsequent issues.
- Assert flush_i with 3 entries plus a concurrent enqueue and wb -> next cycle count_o=0, alu_valid_o=0. Also assert rst mid-stream -> same result.
